aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
- Sequences the AES-256 round-key store and the round datapath.
- Load phase: accepts 15 expanded round keys from the key-expansion block over a valid/ready handshake and writes them into the key store at ascending addresses.
- Run phase: on start, steps through 15 rounds (0..14), presenting key-store read addresses in order (encrypt) or reversed (decrypt), with per-round control flags to the round datapath.
- Sits between the top-level control, the key expansion, the key store and the round datapath.

Parameters:
- NKEYS, 15, number of round keys (initial AddRoundKey plus 14 rounds).
- AW, 4, key-store address width.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- key_load_i  in  1  1-cycle pulse; begin a new key load
- kexp_valid_i  in  1  key-expansion word valid
- kexp_ready_o  out  1  controller accepts a key word
- ks_wr_en_o  out  1  key-store write enable
- ks_wr_addr_o  out  AW  key-store write address
- keys_ok_o  out  1  all NKEYS keys loaded
- start_i  in  1  1-cycle pulse; start a block
- decrypt_i  in  1  mode; sampled with start_i
- busy_o  out  1  load or run in progress
- ks_rd_addr_o  out  AW  key-store read address for the current round
- rnd_valid_o  out  1  round command valid
- rnd_ready_i  in  1  datapath accepts the round
- rnd_first_o  out  1  current round is AddRoundKey-only
- rnd_last_o  out  1  current round omits MixColumns
- done_o  out  1  1-cycle pulse; block finished
- err_o  out  1  1-cycle pulse; start rejected

Behaviour:
- Reset values: FSM=IDLE; key_cnt=0; rnd_cnt=0; keys_ok_o=0; mode=0. All other outputs are 0.
- States: IDLE, LOAD, RUN, FIN.
- IDLE:
  - key_load_i -> LOAD next cycle; key_cnt<=0; keys_ok_o<=0.
  - start_i with keys_ok_o=1 -> RUN; latch decrypt_i; rnd_cnt<=0.
  - start_i with keys_ok_o=0 -> err_o pulse the next cycle; stay in IDLE.
  - key_load_i and start_i in the same cycle: key_load_i wins and err_o pulses.
- LOAD:
  - kexp_ready_o=1, busy_o=1.
  - Each cycle with kexp_valid_i&kexp_ready_o: ks_wr_en_o=1 and ks_wr_addr_o=key_cnt, both combinational in that cycle; key_cnt++.
  - When the write with key_cnt=NKEYS-1 occurs -> IDLE; keys_ok_o<=1.
  - start_i in LOAD -> ignored, err_o pulse.
  - key_load_i in LOAD -> restart: key_cnt<=0.
- RUN:
  - rnd_valid_o=1, busy_o=1.
  - ks_rd_addr_o = mode ? (NKEYS-1-rnd_cnt) : rnd_cnt, registered so it is stable for the whole round.
  - rnd_first_o = (rnd_cnt==0).
  - rnd_last_o = (rnd_cnt==NKEYS-1).
  - On rnd_valid_o&rnd_ready_i: rnd_cnt++. If rnd_cnt was NKEYS-1 -> FIN.
  - Outputs are held unchanged while rnd_ready_i=0 (backpressure).
- Start latency: start_i at cycle t -> rnd_valid_o=1 with round 0 at t+1.
- Run duration: with rnd_ready_i=1 constantly, rounds 0..14 occupy cycles t+1..t+15.
- FIN: done_o=1 for one cycle (t+16 with no backpressure); busy_o=0; -> IDLE. A new start_i is accepted in the following cycle.
- RUN/FIN: key_load_i and start_i are ignored, and each pulses err_o. Keys cannot change mid-block.
- Key retention: keys_ok_o stays 1 across blocks. Only key_load_i or reset clears it.
- Read address when not in RUN: ks_rd_addr_o holds its last value.
- Counter widths: key_cnt and rnd_cnt are AW bits. Compare against NKEYS-1; the counters never wrap past 14.
- Reset mid-load or mid-run: immediate return to reset values. Keys must be reloaded (keys_ok_o=0).

Decomposition:
- Shared package aes_pkg holds:
  - NKEYS=15, NR=14 and AW=4;
  - enum state_t {IDLE, LOAD, RUN, FIN};
  - function rk_addr(cnt, decrypt) for the key-store address mapping.
- Single module with no sub-module. The two counters and the FSM are small enough to stay inline.

Test Plan:
- Load with kexp_valid_i constantly 1 and words 0xK0..0xK14 -> ks_wr_en_o high for 15 consecutive cycles at addresses 0..14; keys_ok_o=1 one cycle after the last write; kexp_ready_o=0 afterwards.
- Encrypt with rnd_ready_i=1 -> ks_rd_addr_o sequence 0,1,...,14 on cycles t+1..t+15; rnd_first_o only at address 0; rnd_last_o only at 14; done_o at t+16.
- Decrypt with the same setup -> address sequence 14,13,...,0; rnd_first_o at address 14; rnd_last_o at address 0; done_o at t+16.
- Backpressure: rnd_ready_i low 3 cycles during round 5 -> address 5 held for 4 cycles total; done_o delayed to t+19.
- Error cases -> err_o pulse with no state change:
  - start_i after reset (no keys);
  - start_i during LOAD;
  - key_load_i during RUN (run completes normally with original addresses).
- Reset mid-run: resetn low at round 7 -> all outputs 0 and keys_ok_o=0; a subsequent start_i gives err_o.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and key-store address mapping for the AES-256 round controller.
package aes_pkg;

  localparam int unsigned NKEYS = 15;
  localparam int unsigned NR    = 14;
  localparam int unsigned AW    = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    FIN
  } state_t;

  // Decrypt walks the schedule backwards: round n uses key NKEYS-1-n.
  function automatic logic [AW-1:0] rk_addr(input logic [AW-1:0] cnt, input logic decrypt);
    return decrypt ? (AW'(NKEYS - 1) - cnt) : cnt;
  endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// AES-256 round controller: loads expanded round keys into the key store, then
// sequences the 15 round commands (forward for encrypt, reversed for decrypt).
module aes_round_ctrl #(
  parameter int unsigned NKEYS = 15,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          key_load_i,
  input  logic          kexp_valid_i,
  output logic          kexp_ready_o,
  output logic          ks_wr_en_o,
  output logic [AW-1:0] ks_wr_addr_o,
  output logic          keys_ok_o,
  input  logic          start_i,
  input  logic          decrypt_i,
  output logic          busy_o,
  output logic [AW-1:0] ks_rd_addr_o,
  output logic          rnd_valid_o,
  input  logic          rnd_ready_i,
  output logic          rnd_first_o,
  output logic          rnd_last_o,
  output logic          done_o,
  output logic          err_o
);
  import aes_pkg::*;

  localparam logic [AW-1:0] LAST = AW'(NKEYS - 1);

  state_t        state, state_d;
  logic [AW-1:0] key_cnt;
  logic [AW-1:0] rnd_cnt;
  logic [AW-1:0] rd_addr;
  logic          keys_ok;
  logic          mode;
  logic          err_q, err_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      key_cnt <= '0;
      rnd_cnt <= '0;
      rd_addr <= '0;
      keys_ok <= 1'b0;
      mode    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_d;
      err_q <= err_d;
      case (state)
        IDLE: begin
          if (key_load_i) begin
            key_cnt <= '0;
            keys_ok <= 1'b0;
          end else if (start_i && keys_ok) begin
            mode    <= decrypt_i;
            rnd_cnt <= '0;
            rd_addr <= rk_addr('0, decrypt_i);
          end
        end
        LOAD: begin
          if (key_load_i) begin
            key_cnt <= '0;
          end else if (kexp_valid_i) begin
            if (key_cnt == LAST) keys_ok <= 1'b1;
            else                 key_cnt <= key_cnt + 1'b1;
          end
        end
        RUN: begin
          // Address for the next round is registered on acceptance so it is
          // stable for the whole round, including under backpressure.
          if (rnd_ready_i && (rnd_cnt != LAST)) begin
            rnd_cnt <= rnd_cnt + 1'b1;
            rd_addr <= rk_addr(rnd_cnt + 1'b1, mode);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d      = state;
    err_d        = 1'b0;
    kexp_ready_o = 1'b0;
    ks_wr_en_o   = 1'b0;
    ks_wr_addr_o = '0;
    busy_o       = 1'b0;
    rnd_valid_o  = 1'b0;
    rnd_first_o  = 1'b0;
    rnd_last_o   = 1'b0;
    done_o       = 1'b0;
    case (state)
      IDLE: begin
        if (key_load_i) begin
          state_d = LOAD;
          err_d   = start_i;
        end else if (start_i) begin
          if (keys_ok) state_d = RUN;
          else         err_d   = 1'b1;
        end
      end
      LOAD: begin
        busy_o       = 1'b1;
        kexp_ready_o = 1'b1;
        err_d        = start_i;
        if (kexp_valid_i) begin
          ks_wr_en_o   = 1'b1;
          ks_wr_addr_o = key_cnt;
          if (!key_load_i && (key_cnt == LAST)) state_d = IDLE;
        end
      end
      RUN: begin
        busy_o      = 1'b1;
        rnd_valid_o = 1'b1;
        rnd_first_o = (rnd_cnt == '0);
        rnd_last_o  = (rnd_cnt == LAST);
        err_d       = key_load_i | start_i;
        if (rnd_ready_i && (rnd_cnt == LAST)) state_d = FIN;
      end
      FIN: begin
        done_o  = 1'b1;
        err_d   = key_load_i | start_i;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign keys_ok_o    = keys_ok;
  assign ks_rd_addr_o = rd_addr;
  assign err_o        = err_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: load table, directed runs and randomized runs vs. a round-sequence model.
module tb_aes_round_ctrl;

  localparam int NK = 15;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       key_load_i = 1'b0;
  logic       kexp_valid_i = 1'b0;
  logic       start_i = 1'b0;
  logic       decrypt_i = 1'b0;
  logic       rnd_ready_i = 1'b0;
  logic       kexp_ready_o, ks_wr_en_o, keys_ok_o, busy_o;
  logic       rnd_valid_o, rnd_first_o, rnd_last_o, done_o, err_o;
  logic [3:0] ks_wr_addr_o, ks_rd_addr_o;

  int n_vec = 0;
  int n_err = 0;

  aes_round_ctrl #(.NKEYS(15), .AW(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .key_load_i   (key_load_i),
    .kexp_valid_i (kexp_valid_i),
    .kexp_ready_o (kexp_ready_o),
    .ks_wr_en_o   (ks_wr_en_o),
    .ks_wr_addr_o (ks_wr_addr_o),
    .keys_ok_o    (keys_ok_o),
    .start_i      (start_i),
    .decrypt_i    (decrypt_i),
    .busy_o       (busy_o),
    .ks_rd_addr_o (ks_rd_addr_o),
    .rnd_valid_o  (rnd_valid_o),
    .rnd_ready_i  (rnd_ready_i),
    .rnd_first_o  (rnd_first_o),
    .rnd_last_o   (rnd_last_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no summary, expected completion");
    $fatal(1);
  end

  typedef struct {
    logic kl, st, kv;
    logic e_rdy, e_wr;
    int   e_addr;
    logic e_ok, e_err, e_busy;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mkv(logic kl, logic st, logic kv, logic e_rdy, logic e_wr,
                               int e_addr, logic e_ok, logic e_err, logic e_busy);
    vec_t v;
    v.kl = kl; v.st = st; v.kv = kv;
    v.e_rdy = e_rdy; v.e_wr = e_wr; v.e_addr = e_addr;
    v.e_ok = e_ok; v.e_err = e_err; v.e_busy = e_busy;
    return v;
  endfunction

  // Reference key-schedule order: round i of a block reads key i, or key NK-1-i when decrypting.
  function automatic int exp_addr(int i, bit dec);
    return dec ? (NK - 1 - i) : i;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_kexp_ready"}, kexp_ready_o, 0);
    chk({tag, "_wr_en"},      ks_wr_en_o,   0);
    chk({tag, "_wr_addr"},    ks_wr_addr_o, 0);
    chk({tag, "_keys_ok"},    keys_ok_o,    0);
    chk({tag, "_busy"},       busy_o,       0);
    chk({tag, "_rd_addr"},    ks_rd_addr_o, 0);
    chk({tag, "_valid"},      rnd_valid_o,  0);
    chk({tag, "_first"},      rnd_first_o,  0);
    chk({tag, "_last"},       rnd_last_o,   0);
    chk({tag, "_done"},       done_o,       0);
    chk({tag, "_err"},        err_o,        0);
  endtask

  // Full key load; with gaps the valid line is randomly idle between words.
  task automatic load_keys(input bit gaps);
    int  n = 0;
    int  guard = 0;
    bit  kv;
    key_load_i = 1'b1;
    sample();
    chk("ld_idle_ready", kexp_ready_o, 0);
    tick();
    key_load_i = 1'b0;
    while (n < NK && guard < 300) begin
      kv = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      kexp_valid_i = kv;
      sample();
      chk("ld_ready", kexp_ready_o, 1);
      chk("ld_busy", busy_o, 1);
      chk("ld_wr_en", ks_wr_en_o, kv);
      chk("ld_keys_ok", keys_ok_o, 0);
      if (kv) chk("ld_wr_addr", ks_wr_addr_o, n);
      tick();
      if (kv) n++;
      guard++;
    end
    if (n < NK) chk("ld_timeout_words", n, NK);
    kexp_valid_i = 1'($urandom_range(0, 1));
    sample();
    chk("ld_end_ready", kexp_ready_o, 0);
    chk("ld_end_wr_en", ks_wr_en_o, 0);
    chk("ld_end_keys_ok", keys_ok_o, 1);
    chk("ld_end_busy", busy_o, 0);
    kexp_valid_i = 1'b0;
    tick();
  endtask

  // One block from IDLE. stall_mode: 0 none, 1 three stalls in round 5, 2 random.
  // inj_round injects key_load_i (or start_i) once while that round is presented.
  task automatic run_block(input bit dec, input int stall_mode, input int inj_round, input bit inj_start);
    int idx = 0;
    int cyc = 1;
    int stalls = 0;
    bit rdy, inj, prev_inj, inj_done;
    prev_inj = 1'b0;
    inj_done = 1'b0;
    start_i   = 1'b1;
    decrypt_i = dec;
    sample();
    chk("run_start_busy", busy_o, 0);
    chk("run_start_valid", rnd_valid_o, 0);
    tick();
    start_i   = 1'b0;
    decrypt_i = 1'($urandom_range(0, 1));
    while (idx < NK && cyc < 200) begin
      case (stall_mode)
        0:       rdy = 1'b1;
        1:       rdy = !(idx == 5 && stalls < 3);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      if (!rdy) stalls++;
      rnd_ready_i = rdy;
      inj = (idx == inj_round) && !inj_done;
      if (inj) inj_done = 1'b1;
      key_load_i = inj & ~inj_start;
      start_i    = inj & inj_start;
      sample();
      chk("run_valid", rnd_valid_o, 1);
      chk("run_busy", busy_o, 1);
      chk("run_rd_addr", ks_rd_addr_o, exp_addr(idx, dec));
      chk("run_first", rnd_first_o, idx == 0);
      chk("run_last", rnd_last_o, idx == NK - 1);
      chk("run_done", done_o, 0);
      chk("run_err", err_o, prev_inj);
      chk("run_wr_en", ks_wr_en_o, 0);
      tick();
      prev_inj   = inj;
      key_load_i = 1'b0;
      start_i    = 1'b0;
      if (rdy) idx++;
      cyc++;
    end
    if (idx < NK) chk("run_timeout_rounds", idx, NK);
    rnd_ready_i = 1'b0;
    sample();
    chk("fin_done", done_o, 1);
    chk("fin_valid", rnd_valid_o, 0);
    chk("fin_busy", busy_o, 0);
    chk("fin_err", err_o, prev_inj);
    chk("fin_rd_addr", ks_rd_addr_o, exp_addr(NK - 1, dec));
    chk("fin_latency", cyc, NK + 1 + stalls);
    tick();
    sample();
    chk("post_done", done_o, 0);
    chk("post_err", err_o, 0);
    chk("post_busy", busy_o, 0);
    chk("post_valid", rnd_valid_o, 0);
    chk("post_keys_ok", keys_ok_o, 1);
    chk("post_rd_addr_hold", ks_rd_addr_o, exp_addr(NK - 1, dec));
    tick();
  endtask

  initial begin
    tbl[0]  = mkv(0, 1, 0,  0, 0, 0, 0, 0, 0);  // start without keys
    tbl[1]  = mkv(1, 1, 0,  0, 0, 0, 0, 1, 0);  // load+start together
    tbl[2]  = mkv(0, 0, 1,  1, 1, 0, 0, 1, 1);
    tbl[3]  = mkv(0, 1, 1,  1, 1, 1, 0, 0, 1);  // start during load
    tbl[4]  = mkv(0, 0, 1,  1, 1, 2, 0, 1, 1);
    for (int i = 5; i <= 16; i++) tbl[i] = mkv(0, 0, 1, 1, 1, i - 2, 0, 0, 1);
    tbl[17] = mkv(0, 0, 1,  0, 0, 0, 1, 0, 0);
    tbl[18] = mkv(0, 0, 0,  0, 0, 0, 1, 0, 0);

    resetn = 1'b0;
    #12;
    chk_zero("rst");
    @(negedge clk);
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 19; i++) begin
      key_load_i   = tbl[i].kl;
      start_i      = tbl[i].st;
      kexp_valid_i = tbl[i].kv;
      sample();
      chk($sformatf("tbl%0d_ready", i),   kexp_ready_o, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_wr_en", i),   ks_wr_en_o,   tbl[i].e_wr);
      if (tbl[i].e_wr) chk($sformatf("tbl%0d_wr_addr", i), ks_wr_addr_o, tbl[i].e_addr);
      chk($sformatf("tbl%0d_keys_ok", i), keys_ok_o,    tbl[i].e_ok);
      chk($sformatf("tbl%0d_err", i),     err_o,        tbl[i].e_err);
      chk($sformatf("tbl%0d_busy", i),    busy_o,       tbl[i].e_busy);
      tick();
    end
    key_load_i   = 1'b0;
    start_i      = 1'b0;
    kexp_valid_i = 1'b0;

    run_block(1'b0, 0, -1, 1'b0);   // encrypt
    run_block(1'b1, 0, -1, 1'b0);   // decrypt
    run_block(1'b0, 1, -1, 1'b0);   // backpressure in round 5
    run_block(1'b0, 0,  3, 1'b0);   // key_load during run
    run_block(1'b1, 0, 14, 1'b1);   // start during the last round

    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 2) == 0) load_keys(1'b1);
      run_block(1'($urandom_range(0, 1)), 2, int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
    end

    // Reset while round 7 is presented.
    start_i   = 1'b1;
    decrypt_i = 1'b0;
    tick();
    start_i     = 1'b0;
    rnd_ready_i = 1'b1;
    repeat (7) tick();
    sample();
    chk("mid_rd_addr", ks_rd_addr_o, 7);
    #1 resetn = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk);
    resetn = 1'b1;
    tick();
    rnd_ready_i = 1'b0;
    start_i = 1'b1;
    sample();
    chk("rst_start_busy", busy_o, 0);
    tick();
    start_i = 1'b0;
    sample();
    chk("rst_start_err", err_o, 1);
    chk("rst_keys_ok", keys_ok_o, 0);
    chk("rst_valid", rnd_valid_o, 0);
    tick();
    sample();
    chk("rst_err_clear", err_o, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
